sdram_port_sched: RTL and testbench
===================================

# sdram_port_sched

Burst scheduler between the four user FIFOs (write ports 0/1, read ports 0/1) and the single-port SDRAM controller. It watches the FIFO fill levels, picks one eligible port per burst by round-robin, and issues the corresponding write or read request with a per-port address pointer. It also selects which FIFO the controller data path is steered to, and advances and wraps the address pointers.

## Interface
Parameters:
- ADDR_W, 21, SDRAM word address width; MSB selects the port region (port p uses {p, ptr[ADDR_W-2:0]})
- LEN_W, 10, burst length width
- CNT_W, 11, FIFO fill-count width
- RD_DEPTH, 1024, read FIFO capacity in words

Ports:
- sys_clk  in  1  controller clock
- sys_rst_n  in  1  asynchronous active-low reset
- init_done  in  1  SDRAM initialisation complete
- read_valid  in  1  read ports enabled
- wr_rst, rd_rst  in  1  synchronous pointer reset for write / read ports
- wr_cnt0, wr_cnt1  in  CNT_W  words held in write FIFOs
- rd_cnt0, rd_cnt1  in  CNT_W  words held in read FIFOs
- wr_burst_len, rd_burst_len  in  LEN_W  burst lengths (nonzero)
- wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr  in  ADDR_W-1  inclusive region bounds (offset part)
- sdram_wr_req  out  1  write request
- sdram_wr_ack  in  1  high for the duration of the write burst
- sdram_wr_addr  out  ADDR_W  write start address
- wr_sel  out  1  write FIFO feeding the controller
- sdram_rd_req, sdram_rd_ack, sdram_rd_addr, rd_sel  (same as write side, read direction)
- busy  out  1  burst granted and not yet complete

## Operation
- FSM: IDLE -> ARB on init_done; the offset pointers load their min_addr on this transition.
- ARB -> WR / RD on a grant; WR/RD -> ARB after ack falls.
- Eligibility is sampled in ARB:
  - W_p: wr_cnt_p >= wr_burst_len.
  - R_p: read_valid && rd_cnt_p + rd_burst_len <= RD_DEPTH, computed in CNT_W+1 bits.
- Round-robin order W0, W1, R0, R1. Search starts at the candidate after the last grant; the last grant resets to R1, so W0 is first.
- WR/RD:
  - Assert req, with addr = {p, ptr_p} and sel = p.
  - Deassert req the cycle after ack is seen high.
  - Stay in the state until ack falls.
  - On the fall, advance the pointer: next = ptr + len, computed in ADDR_W bits. If next + len > max + 1, next = min.
- wr_rst / rd_rst:
  - Set both pointers of that direction to min at once.
  - If a burst of that direction is in flight, it completes but its pointer advance is suppressed.
- init_done falling is honoured only in ARB, returning to IDLE.
- Reset values:
  - All req, sel and busy = 0; addrs = 0; pointers = 0.
  - State IDLE; last grant = R1.

## Timing
- Eligible at ARB cycle N -> req and addr registered high at N+1; busy high at N+1.
- addr and sel are stable from req rise until ack falls.
- Ack falls at cycle M -> pointer updated and state = ARB at M+1, so the earliest next req is at M+2.
- Requests are never concurrent: at most one of wr_req / rd_req is high.
- Simultaneous eligibility resolves by round-robin only; there is no direction priority.

## Structure
- Package sdram_sched_pkg:
  - state enum (IDLE, ARB, WR, RD)
  - candidate index constants (CAND_W0..CAND_R1)
  - pointer-wrap function
- Sub-module rr_arbiter4: 4-bit request vector and last-grant in -> one-hot grant out, combinational.

## Test plan
- Reset, then init_done high, wr_min = 0x100, len = 256, wr_cnt0 = 256 -> wr_req at N+1, addr 0x000100, wr_sel = 0.
- wr_cnt0 = wr_cnt1 = 512, rd_cnt0 = 0, read_valid = 1, rd_min = 0, len = 256 -> grant order W0, W1, R0, R1, W0; each req only after the previous ack falls.
- wr_min = 0, wr_max = 0x3FF, len = 256; five W0 bursts -> addrs 0x000, 0x100, 0x200, 0x300, 0x000.
- rd_cnt0 = 900, RD_DEPTH = 1024, len = 256 -> R0 never granted; rd_cnt0 = 768 -> granted.
- wr_rst pulsed during a W1 burst at ptr 0x200 -> burst completes, next W1 addr = {1, wr_min}.
- sys_rst_n low mid-burst -> all outputs 0 immediately, FSM IDLE, pointers 0.

Source files
------------

// File: rtl/sdram_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_sched_pkg
// Brief    : Shared types, candidate indices and pointer-wrap helper for the
//            SDRAM burst scheduler.
// Revision : 1.0
// ============================================================================
package sdram_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_t;

    // Round-robin candidate order; bit 1 = read direction, bit 0 = port
    localparam logic [1:0] CAND_W0 = 2'd0;
    localparam logic [1:0] CAND_W1 = 2'd1;
    localparam logic [1:0] CAND_R0 = 2'd2;
    localparam logic [1:0] CAND_R1 = 2'd3;

    // Advance a region pointer by one burst; fall back to the region start
    // when the following burst would not fit below max (inclusive).
    // Done in 32 bits so no intermediate sum can overflow.
    function automatic logic [31:0] ptr_wrap(
        input logic [31:0] ptr,
        input logic [31:0] len,
        input logic [31:0] min_a,
        input logic [31:0] max_a
    );
        logic [31:0] nxt;
        nxt = ptr + len;
        if (nxt + len > max_a + 32'd1)
            ptr_wrap = min_a;
        else
            ptr_wrap = nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4
// Brief    : Combinational 4-way round-robin arbiter. Search starts at the
//            candidate after the last grant; output is one-hot (or zero).
// Revision : 1.0
// ============================================================================
module rr_arbiter4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_last,
    output logic [3:0] o_grant
);

    logic       w_found;
    logic [1:0] w_idx;

    // Walk last+1 .. last+4 (mod 4) and take the first requester
    always_comb begin
        o_grant = 4'b0000;
        w_found = 1'b0;
        w_idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = i_last + 2'(i);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_sched
// Brief    : Burst scheduler between two write FIFOs, two read FIFOs and a
//            single-port SDRAM controller. Round-robin per burst, per-port
//            wrapping address pointers, FIFO steering selects.
// Revision : 1.0
// ============================================================================
module sdram_port_sched
    import sdram_sched_pkg::*;
#(
    parameter int ADDR_W   = 21,
    parameter int LEN_W    = 10,
    parameter int CNT_W    = 11,
    parameter int RD_DEPTH = 1024
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_done,
    input  logic              read_valid,
    input  logic              wr_rst,
    input  logic              rd_rst,
    input  logic [CNT_W-1:0]  wr_cnt0,
    input  logic [CNT_W-1:0]  wr_cnt1,
    input  logic [CNT_W-1:0]  rd_cnt0,
    input  logic [CNT_W-1:0]  rd_cnt1,
    input  logic [LEN_W-1:0]  wr_burst_len,
    input  logic [LEN_W-1:0]  rd_burst_len,
    input  logic [ADDR_W-2:0] wr_min_addr,
    input  logic [ADDR_W-2:0] wr_max_addr,
    input  logic [ADDR_W-2:0] rd_min_addr,
    input  logic [ADDR_W-2:0] rd_max_addr,
    output logic              sdram_wr_req,
    input  logic              sdram_wr_ack,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic              wr_sel,
    output logic              sdram_rd_req,
    input  logic              sdram_rd_ack,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    output logic              rd_sel,
    output logic              busy
);

    localparam int OFS_W = ADDR_W - 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_last;
    logic [1:0]        r_cur;
    logic              r_ack_seen;
    logic              r_sup;
    logic [OFS_W-1:0]  r_ptr [4];
    logic              r_wr_req, r_rd_req, r_wr_sel, r_rd_sel, r_busy;
    logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;

    logic [3:0]        w_elig;
    logic [3:0]        w_grant;
    logic [1:0]        w_grant_idx;
    logic              w_any;
    logic              w_fire;
    logic              w_ack_cur;
    logic              w_done;
    logic [CNT_W:0]    w_rd_need;
    logic [OFS_W-1:0]  w_next;

    // Eligibility: writes need a full burst buffered, reads need room for one
    assign w_rd_need = (CNT_W+1)'(rd_burst_len);
    assign w_elig[0] = (wr_cnt0 >= CNT_W'(wr_burst_len));
    assign w_elig[1] = (wr_cnt1 >= CNT_W'(wr_burst_len));
    assign w_elig[2] = read_valid && (({1'b0, rd_cnt0} + w_rd_need) <= (CNT_W+1)'(RD_DEPTH));
    assign w_elig[3] = read_valid && (({1'b0, rd_cnt1} + w_rd_need) <= (CNT_W+1)'(RD_DEPTH));

    rr_arbiter4 u_arb (
        .i_req   (w_elig),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    // One-hot grant to candidate index
    always_comb begin
        w_grant_idx = CAND_W0;
        case (w_grant)
            4'b0010: w_grant_idx = CAND_W1;
            4'b0100: w_grant_idx = CAND_R0;
            4'b1000: w_grant_idx = CAND_R1;
            default: w_grant_idx = CAND_W0;
        endcase
    end

    assign w_any     = |w_grant;
    assign w_fire    = (r_state == ST_ARB) && init_done && w_any;
    assign w_ack_cur = (r_state == ST_WR) ? sdram_wr_ack : sdram_rd_ack;
    assign w_done    = ((r_state == ST_WR) || (r_state == ST_RD)) && r_ack_seen && !w_ack_cur;
    assign w_next    = OFS_W'(ptr_wrap(32'(r_ptr[r_cur]),
                                       32'(r_cur[1] ? rd_burst_len : wr_burst_len),
                                       32'(r_cur[1] ? rd_min_addr  : wr_min_addr),
                                       32'(r_cur[1] ? rd_max_addr  : wr_max_addr)));

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Next-state: init_done drop only honoured between bursts
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (init_done) w_state_nxt = ST_ARB;
            ST_ARB: begin
                if (!init_done)  w_state_nxt = ST_IDLE;
                else if (w_any)  w_state_nxt = w_grant_idx[1] ? ST_RD : ST_WR;
            end
            ST_WR, ST_RD: if (w_done) w_state_nxt = ST_ARB;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request/address/select registers and burst bookkeeping
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_last     <= CAND_R1;
            r_cur      <= CAND_W0;
            r_ack_seen <= 1'b0;
            r_sup      <= 1'b0;
            r_wr_req   <= 1'b0;
            r_rd_req   <= 1'b0;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
        end else begin
            if (w_fire) begin
                r_last     <= w_grant_idx;
                r_cur      <= w_grant_idx;
                r_busy     <= 1'b1;
                r_ack_seen <= 1'b0;
                // A pointer reset coinciding with the grant still voids this burst's advance
                r_sup      <= w_grant_idx[1] ? rd_rst : wr_rst;
                if (w_grant_idx[1]) begin
                    r_rd_req  <= 1'b1;
                    r_rd_sel  <= w_grant_idx[0];
                    r_rd_addr <= {w_grant_idx[0], r_ptr[w_grant_idx]};
                end else begin
                    r_wr_req  <= 1'b1;
                    r_wr_sel  <= w_grant_idx[0];
                    r_wr_addr <= {w_grant_idx[0], r_ptr[w_grant_idx]};
                end
            end else if (w_done) begin
                r_busy     <= 1'b0;
                r_ack_seen <= 1'b0;
                r_sup      <= 1'b0;
            end else begin
                if (r_state == ST_WR && sdram_wr_ack) begin
                    r_wr_req   <= 1'b0;
                    r_ack_seen <= 1'b1;
                end
                if (r_state == ST_RD && sdram_rd_ack) begin
                    r_rd_req   <= 1'b0;
                    r_ack_seen <= 1'b1;
                end
                if ((r_state == ST_WR && wr_rst) || (r_state == ST_RD && rd_rst))
                    r_sup <= 1'b1;
            end
        end
    end

    // Pointers: load on start-up, direction reset, or advance at burst end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int p = 0; p < 4; p++) r_ptr[p] <= '0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (r_state == ST_IDLE && init_done)
                    r_ptr[p] <= (p < 2) ? wr_min_addr : rd_min_addr;
                else if ((p < 2) ? wr_rst : rd_rst)
                    r_ptr[p] <= (p < 2) ? wr_min_addr : rd_min_addr;
                else if (w_done && !r_sup && (r_cur == 2'(p)))
                    r_ptr[p] <= w_next;
            end
        end
    end

    assign sdram_wr_req  = r_wr_req;
    assign sdram_rd_req  = r_rd_req;
    assign sdram_wr_addr = r_wr_addr;
    assign sdram_rd_addr = r_rd_addr;
    assign wr_sel        = r_wr_sel;
    assign rd_sel        = r_rd_sel;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_sched
// Brief    : Scoreboard bench for sdram_port_sched: directed scenarios push
//            expected grants, a monitor checks each request as it appears.
// Revision : 1.0
// ============================================================================
module tb_sdram_port_sched;

    localparam int ADDR_W   = 21;
    localparam int LEN_W    = 10;
    localparam int CNT_W    = 11;
    localparam int RD_DEPTH = 1024;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              init_done = 1'b0, read_valid = 1'b0;
    logic              wr_rst = 1'b0, rd_rst = 1'b0;
    logic [CNT_W-1:0]  wr_cnt0 = '0, wr_cnt1 = '0, rd_cnt0 = '0, rd_cnt1 = '0;
    logic [LEN_W-1:0]  wr_burst_len = 10'd256, rd_burst_len = 10'd256;
    logic [ADDR_W-2:0] wr_min_addr = '0, wr_max_addr = 20'h003FF;
    logic [ADDR_W-2:0] rd_min_addr = '0, rd_max_addr = 20'h003FF;
    logic              sdram_wr_ack = 1'b0, sdram_rd_ack = 1'b0;
    logic              sdram_wr_req, sdram_rd_req, wr_sel, rd_sel, busy;
    logic [ADDR_W-1:0] sdram_wr_addr, sdram_rd_addr;

    sdram_port_sched #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .RD_DEPTH(RD_DEPTH)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
        .read_valid(read_valid), .wr_rst(wr_rst), .rd_rst(rd_rst),
        .wr_cnt0(wr_cnt0), .wr_cnt1(wr_cnt1), .rd_cnt0(rd_cnt0), .rd_cnt1(rd_cnt1),
        .wr_burst_len(wr_burst_len), .rd_burst_len(rd_burst_len),
        .wr_min_addr(wr_min_addr), .wr_max_addr(wr_max_addr),
        .rd_min_addr(rd_min_addr), .rd_max_addr(rd_max_addr),
        .sdram_wr_req(sdram_wr_req), .sdram_wr_ack(sdram_wr_ack),
        .sdram_wr_addr(sdram_wr_addr), .wr_sel(wr_sel),
        .sdram_rd_req(sdram_rd_req), .sdram_rd_ack(sdram_rd_ack),
        .sdram_rd_addr(sdram_rd_addr), .rd_sel(rd_sel), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic        rd;
        logic        port;
        logic [20:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, errors = 0;
    int   n_seen = 0, cyc = 0, last_fall = 0;
    bit   have_fall = 1'b0, gap_exact = 1'b0;
    logic prev_wr_req = 1'b0, prev_rd_req = 1'b0, prev_ack = 1'b0;
    logic rise_w, rise_r, mon_sel;
    logic [20:0] mon_addr;
    exp_t mon_e;

    function automatic exp_t mk(input logic rd, input logic port, input logic [20:0] addr);
        exp_t e;
        e.rd = rd; e.port = port; e.addr = addr;
        return e;
    endfunction

    // Controller model: ack two cycles after a request, held four cycles
    initial forever begin
        @(posedge sys_clk); #1;
        if (sdram_wr_req && !sdram_wr_ack) begin
            repeat (2) @(posedge sys_clk);
            #1 sdram_wr_ack = 1'b1;
            repeat (4) @(posedge sys_clk);
            #1 sdram_wr_ack = 1'b0;
        end else if (sdram_rd_req && !sdram_rd_ack) begin
            repeat (2) @(posedge sys_clk);
            #1 sdram_rd_ack = 1'b1;
            repeat (4) @(posedge sys_clk);
            #1 sdram_rd_ack = 1'b0;
        end
    end

    // Monitor: every request rise is popped against the scoreboard
    initial forever begin
        @(negedge sys_clk);
        cyc++;
        if (prev_ack && !(sdram_wr_ack || sdram_rd_ack)) begin
            last_fall = cyc;
            have_fall = 1'b1;
        end
        rise_w = sdram_wr_req && !prev_wr_req;
        rise_r = sdram_rd_req && !prev_rd_req;
        if (rise_w || rise_r) begin
            n_seen++;
            checks++;
            if (sdram_wr_req && sdram_rd_req) begin
                errors++;
                $display("FAIL concurrent_req: wr_req=%0b rd_req=%0b required not both", sdram_wr_req, sdram_rd_req);
            end
            mon_addr = rise_r ? sdram_rd_addr : sdram_wr_addr;
            mon_sel  = rise_r ? rd_sel : wr_sel;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req: rd=%0b sel=%0b addr=%h required no request", rise_r, mon_sel, mon_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if (rise_r !== mon_e.rd || mon_sel !== mon_e.port || mon_addr !== mon_e.addr) begin
                    errors++;
                    $display("FAIL grant: got rd=%0b sel=%0b addr=%h required rd=%0b sel=%0b addr=%h",
                             rise_r, mon_sel, mon_addr, mon_e.rd, mon_e.port, mon_e.addr);
                end
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_with_req: busy=%0b required 1", busy);
            end
            if (gap_exact && have_fall) begin
                checks++;
                if (cyc - last_fall != 2) begin
                    errors++;
                    $display("FAIL ack_to_req_gap: got %0d cycles required 2", cyc - last_fall);
                end
            end
        end
        prev_wr_req = sdram_wr_req;
        prev_rd_req = sdram_rd_req;
        prev_ack    = sdram_wr_ack || sdram_rd_ack;
    end

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0b required %0b", name, got, req);
        end
    endtask

    task automatic check_outs_zero(input string name);
        logic [47:0] v;
        v = {sdram_wr_req, sdram_rd_req, busy, wr_sel, rd_sel, sdram_wr_addr, sdram_rd_addr};
        checks++;
        if (v !== 48'd0) begin
            errors++;
            $display("FAIL %s: outputs %h required 0", name, v);
        end
    endtask

    task automatic quiesce_inputs();
        init_done = 1'b0; read_valid = 1'b0; wr_rst = 1'b0; rd_rst = 1'b0;
        wr_cnt0 = '0; wr_cnt1 = '0; rd_cnt0 = '0; rd_cnt1 = '0;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        quiesce_inputs();
        wr_min_addr = '0; wr_max_addr = 20'h003FF;
        rd_min_addr = '0; rd_max_addr = 20'h003FF;
        #1 check_outs_zero("reset_outputs");
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        have_fall = 1'b0;
        gap_exact = 1'b0;
        n_seen    = 0;
        exp_q.delete();
    endtask

    task automatic wait_seen(input int n);
        int k = 0;
        while (n_seen < n && k < 400) begin
            @(negedge sys_clk);
            k++;
        end
        checks++;
        if (n_seen < n) begin
            errors++;
            $display("FAIL wait_grants: got %0d required %0d", n_seen, n);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || sdram_wr_ack || sdram_rd_ack || sdram_wr_req || sdram_rd_req) && k < 400) begin
            @(negedge sys_clk);
            k++;
        end
        check_bit("wait_idle_busy", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: single W0 burst, latency and address offset
        do_reset();
        wr_min_addr = 20'h00100;
        wr_cnt0 = 11'd256;
        exp_q.push_back(mk(1'b0, 1'b0, 21'h000100));
        @(negedge sys_clk); init_done = 1'b1;
        @(negedge sys_clk); check_bit("t1_no_req_in_arb", sdram_wr_req, 1'b0);
        @(negedge sys_clk); check_bit("t1_req_next_cycle", sdram_wr_req, 1'b1);
        check_bit("t1_busy", busy, 1'b1);
        wait_seen(1);
        wr_cnt0 = '0;
        wait_idle();

        // 2: round-robin W0, W1, R0, R1, W0
        do_reset();
        wr_cnt0 = 11'd512; wr_cnt1 = 11'd512; read_valid = 1'b1;
        gap_exact = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 21'h000000));
        exp_q.push_back(mk(1'b0, 1'b1, 21'h100000));
        exp_q.push_back(mk(1'b1, 1'b0, 21'h000000));
        exp_q.push_back(mk(1'b1, 1'b1, 21'h100000));
        exp_q.push_back(mk(1'b0, 1'b0, 21'h000100));
        @(negedge sys_clk); init_done = 1'b1;
        wait_seen(5);
        quiesce_inputs(); init_done = 1'b1;
        wait_idle();

        // 3: pointer advance and wrap at max
        do_reset();
        wr_cnt0 = 11'd256;
        gap_exact = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 21'h000000));
        exp_q.push_back(mk(1'b0, 1'b0, 21'h000100));
        exp_q.push_back(mk(1'b0, 1'b0, 21'h000200));
        exp_q.push_back(mk(1'b0, 1'b0, 21'h000300));
        exp_q.push_back(mk(1'b0, 1'b0, 21'h000000));
        @(negedge sys_clk); init_done = 1'b1;
        wait_seen(5);
        wr_cnt0 = '0;
        wait_idle();

        // 4: read room boundary
        do_reset();
        rd_min_addr = 20'h00010;
        read_valid = 1'b1; rd_cnt0 = 11'd900; rd_cnt1 = 11'd1024;
        @(negedge sys_clk); init_done = 1'b1;
        repeat (20) @(negedge sys_clk);
        check_bit("t4_no_grant_900", sdram_rd_req | sdram_wr_req | busy, 1'b0);
        rd_cnt0 = 11'd769;
        repeat (8) @(negedge sys_clk);
        check_bit("t4_no_grant_769", sdram_rd_req | sdram_wr_req | busy, 1'b0);
        exp_q.push_back(mk(1'b1, 1'b0, 21'h000010));
        rd_cnt0 = 11'd768;
        wait_seen(1);
        rd_cnt0 = 11'd1024;
        wait_idle();

        // 5: write pointer reset during a W1 burst suppresses its advance
        do_reset();
        wr_min_addr = 20'h00040; wr_max_addr = 20'h007FF;
        wr_cnt1 = 11'd256;
        gap_exact = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b1, 21'h100040));
        exp_q.push_back(mk(1'b0, 1'b1, 21'h100140));
        exp_q.push_back(mk(1'b0, 1'b1, 21'h100240));
        exp_q.push_back(mk(1'b0, 1'b1, 21'h100040));
        @(negedge sys_clk); init_done = 1'b1;
        wait_seen(3);
        wr_rst = 1'b1;
        @(negedge sys_clk); wr_rst = 1'b0;
        wait_seen(4);
        wr_cnt1 = '0;
        wait_idle();

        // 6: asynchronous reset mid-burst
        do_reset();
        wr_cnt0 = 11'd256;
        exp_q.push_back(mk(1'b0, 1'b0, 21'h000000));
        @(negedge sys_clk); init_done = 1'b1;
        wait_seen(1);
        #2 sys_rst_n = 1'b0;
        init_done = 1'b0;
        #1 check_outs_zero("t6_async_reset");
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        check_bit("t6_idle_after_reset", sdram_wr_req | sdram_rd_req | busy, 1'b0);
        wr_cnt0 = '0;
        wait_idle();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected grants left, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
